// File: rtl/alarm_clock_controller_if.sv
// Button inputs and time/alarm outputs of the alarm clock controller.
// master drives the debounced buttons; slave is the controller itself.
interface alarm_clock_controller_if;
  logic       btn_set_time;
  logic       btn_inc_hours;
  logic       btn_inc_mins;
  logic       btn_alarm_en;
  logic [2:0] mode;
  logic [7:0] current_hours;
  logic [7:0] current_mins;
  logic [7:0] current_secs;
  logic [7:0] alarm_hours;
  logic [7:0] alarm_mins;
  logic       alarm_enabled;
  logic       alarm_active;

  modport master (
    output btn_set_time, btn_inc_hours, btn_inc_mins, btn_alarm_en,
    input  mode, current_hours, current_mins, current_secs,
           alarm_hours, alarm_mins, alarm_enabled, alarm_active
  );

  modport slave (
    input  btn_set_time, btn_inc_hours, btn_inc_mins, btn_alarm_en,
    output mode, current_hours, current_mins, current_secs,
           alarm_hours, alarm_mins, alarm_enabled, alarm_active
  );
endinterface

// File: rtl/alarm_clock_controller.sv
// Alarm clock sequencer: button press detection, mode FSM, time-of-day
// counters driven by a one-second tick, and alarm match/dismiss logic.
//
// state | meaning
// ------+---------------------------------------------
// RUN   | time runs, inc buttons ignored
// ST_H  | set time hours, time frozen
// ST_M  | set time minutes, time frozen
// SA_H  | set alarm hours, time runs
// SA_M  | set alarm minutes, time runs
module alarm_clock_controller #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input logic clk,
  input logic reset,
  alarm_clock_controller_if.slave bus
);
  localparam int CW = $clog2(TICKS_PER_SEC);
  localparam logic [2:0] RUN  = 3'd0;
  localparam logic [2:0] ST_H = 3'd1;
  localparam logic [2:0] ST_M = 3'd2;
  localparam logic [2:0] SA_H = 3'd3;
  localparam logic [2:0] SA_M = 3'd4;

  logic [2:0]    state, state_nxt;
  logic [3:0]    btn_now, btn_q, press;
  logic [CW-1:0] tick_cnt;
  logic [7:0]    hours, mins, secs, al_hours, al_mins;
  logic          al_en, al_act, act_nxt;
  logic          dismiss, advance, toggle_en, tick, match;
  logic          frozen, inc_th, inc_tm, inc_ah, inc_am, clr_secs;
  logic          secs_wrap, mins_wrap;
  logic [7:0]    tick_secs, tick_mins, tick_hours;

  assign btn_now = {bus.btn_alarm_en, bus.btn_inc_mins, bus.btn_inc_hours, bus.btn_set_time};
  assign press   = btn_now & ~btn_q;
  // a press while sounding only silences the alarm
  assign dismiss   = al_act & (|press);
  assign advance   = press[0] & ~dismiss;
  assign toggle_en = press[3] & ~dismiss;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (advance) state_nxt = ST_H;
      ST_H:    if (advance) state_nxt = ST_M;
      ST_M:    if (advance) state_nxt = SA_H;
      SA_H:    if (advance) state_nxt = SA_M;
      SA_M:    if (advance) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    frozen   = 1'b0;
    inc_th   = 1'b0;
    inc_tm   = 1'b0;
    inc_ah   = 1'b0;
    inc_am   = 1'b0;
    clr_secs = 1'b0;
    case (state)
      ST_H: begin
        frozen = 1'b1;
        inc_th = press[1] & ~dismiss & ~press[0];
      end
      ST_M: begin
        frozen   = 1'b1;
        inc_tm   = press[2] & ~dismiss & ~press[0];
        clr_secs = advance;
      end
      SA_H:    inc_ah = press[1] & ~dismiss & ~press[0];
      SA_M:    inc_am = press[2] & ~dismiss & ~press[0];
      default: ;
    endcase
  end

  assign tick       = ~frozen & (tick_cnt == CW'(TICKS_PER_SEC - 1));
  assign secs_wrap  = (secs == 8'd59);
  assign mins_wrap  = (mins == 8'd59);
  assign tick_secs  = secs_wrap ? 8'd0 : secs + 8'd1;
  assign tick_mins  = secs_wrap ? (mins_wrap ? 8'd0 : mins + 8'd1) : mins;
  assign tick_hours = (secs_wrap && mins_wrap) ? ((hours == 8'd23) ? 8'd0 : hours + 8'd1) : hours;
  assign match      = tick & secs_wrap & al_en & (tick_mins == al_mins) & (tick_hours == al_hours);

  // a fresh match outranks dismiss/auto-clear; disabling outranks everything
  always_comb begin
    act_nxt = al_act;
    if (dismiss || (tick && secs_wrap)) act_nxt = 1'b0;
    if (match) act_nxt = 1'b1;
    if (toggle_en && al_en) act_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q    <= '1;
      tick_cnt <= '0;
      hours    <= '0;
      mins     <= '0;
      secs     <= '0;
      al_hours <= '0;
      al_mins  <= '0;
      al_en    <= 1'b0;
      al_act   <= 1'b0;
    end else begin
      btn_q    <= btn_now;
      tick_cnt <= (frozen || tick) ? '0 : tick_cnt + 1'b1;
      if (tick) begin
        secs  <= tick_secs;
        mins  <= tick_mins;
        hours <= tick_hours;
      end
      if (clr_secs) secs <= '0;
      if (inc_th) hours <= (hours == 8'd23) ? 8'd0 : hours + 8'd1;
      if (inc_tm) mins <= (mins == 8'd59) ? 8'd0 : mins + 8'd1;
      if (inc_ah) al_hours <= (al_hours == 8'd23) ? 8'd0 : al_hours + 8'd1;
      if (inc_am) al_mins <= (al_mins == 8'd59) ? 8'd0 : al_mins + 8'd1;
      if (toggle_en) al_en <= ~al_en;
      al_act <= act_nxt;
    end
  end

  assign bus.mode          = state;
  assign bus.current_hours = hours;
  assign bus.current_mins  = mins;
  assign bus.current_secs  = secs;
  assign bus.alarm_hours   = al_hours;
  assign bus.alarm_mins    = al_mins;
  assign bus.alarm_enabled = al_en;
  assign bus.alarm_active  = al_act;
endmodule

// File: tb/tb_alarm_clock_controller.sv
// Bench for alarm_clock_controller: directed scenarios plus random button
// traffic, checked every cycle against a seconds-of-day reference model.
module tb_alarm_clock_controller;
  localparam int TPS = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  bit   chk_on;

  alarm_clock_controller_if bus();

  alarm_clock_controller #(.TICKS_PER_SEC(TPS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: time kept as seconds since midnight
  int m_t, m_cnt, m_mode, m_ah, m_am;
  bit m_en, m_act;
  bit q_s, q_h, q_m, q_e;
  bit ps, ph, pm, pe, dis, frz, tk;
  int n_t, n_cnt, n_mode, n_ah, n_am, hh, mm, ss;
  bit n_en, n_act;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_t = 0; m_cnt = 0; m_mode = 0; m_ah = 0; m_am = 0;
      m_en = 0; m_act = 0;
      q_s = 1; q_h = 1; q_m = 1; q_e = 1;
    end else begin
      ps = bus.btn_set_time  && !q_s;
      ph = bus.btn_inc_hours && !q_h;
      pm = bus.btn_inc_mins  && !q_m;
      pe = bus.btn_alarm_en  && !q_e;
      q_s = bus.btn_set_time; q_h = bus.btn_inc_hours;
      q_m = bus.btn_inc_mins; q_e = bus.btn_alarm_en;
      hh = m_t / 3600; mm = (m_t / 60) % 60; ss = m_t % 60;
      dis = m_act && (ps || ph || pm || pe);
      frz = (m_mode == 1) || (m_mode == 2);
      tk  = !frz && (m_cnt == TPS - 1);
      n_t   = tk ? (m_t + 1) % 86400 : m_t;
      n_cnt = (frz || tk) ? 0 : m_cnt + 1;
      n_mode = m_mode; n_ah = m_ah; n_am = m_am; n_en = m_en; n_act = m_act;
      if (dis) n_act = 0;
      if (tk && (n_t / 60 != m_t / 60)) n_act = 0;
      if (tk && m_en && (n_t % 60 == 0) && ((n_t / 60) % 60 == m_am) && (n_t / 3600 == m_ah))
        n_act = 1;
      if (!dis) begin
        if (ps) begin
          n_mode = (m_mode + 1) % 5;
          if (m_mode == 2) begin n_t = hh * 3600 + mm * 60; n_cnt = 0; end
        end
        else if (ph && m_mode == 1) n_t = ((hh + 1) % 24) * 3600 + mm * 60 + ss;
        else if (pm && m_mode == 2) n_t = hh * 3600 + ((mm + 1) % 60) * 60 + ss;
        else if (ph && m_mode == 3) n_ah = (m_ah + 1) % 24;
        else if (pm && m_mode == 4) n_am = (m_am + 1) % 60;
        if (pe) begin n_en = !m_en; if (m_en) n_act = 0; end
      end
      m_t = n_t; m_cnt = n_cnt; m_mode = n_mode; m_ah = n_ah; m_am = n_am;
      m_en = n_en; m_act = n_act;
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on && !reset) begin
      cmp("model_mode",    32'(bus.mode),          m_mode);
      cmp("model_hours",   32'(bus.current_hours), m_t / 3600);
      cmp("model_mins",    32'(bus.current_mins),  (m_t / 60) % 60);
      cmp("model_secs",    32'(bus.current_secs),  m_t % 60);
      cmp("model_al_h",    32'(bus.alarm_hours),   m_ah);
      cmp("model_al_m",    32'(bus.alarm_mins),    m_am);
      cmp("model_enabled", 32'(bus.alarm_enabled), 32'(m_en));
      cmp("model_active",  32'(bus.alarm_active),  32'(m_act));
    end
  end

  task automatic set_btn(input int which, input logic v);
    case (which)
      0: bus.btn_set_time  = v;
      1: bus.btn_inc_hours = v;
      2: bus.btn_inc_mins  = v;
      default: bus.btn_alarm_en = v;
    endcase
  endtask

  task automatic pulse(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      set_btn(which, 1'b1);
      @(negedge clk);
      set_btn(which, 1'b0);
      @(negedge clk);
    end
  endtask

  task automatic wait_secs(input int target, input int budget);
    int n = 0;
    while (32'(bus.current_secs) != target && n < budget) begin @(negedge clk); n++; end
    if (32'(bus.current_secs) != target) begin
      checks++; failures++;
      $display("FAIL timeout_secs actual=%0d expected=%0d", bus.current_secs, target);
    end
  endtask

  task automatic wait_active(input logic v, input int budget);
    int n = 0;
    while (bus.alarm_active !== v && n < budget) begin @(negedge clk); n++; end
    if (bus.alarm_active !== v) begin
      checks++; failures++;
      $display("FAIL timeout_active actual=%0d expected=%0d", bus.alarm_active, v);
    end
  endtask

  initial begin
    int n;
    logic [7:0] s0;
    checks = 0; failures = 0; chk_on = 0;
    bus.btn_set_time = 1'b1; bus.btn_inc_hours = 1'b0;
    bus.btn_inc_mins = 1'b0; bus.btn_alarm_en = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_on = 1;

    // 1: button held through reset produces no press
    repeat (3) @(negedge clk);
    cmp("held_mode", 32'(bus.mode), 0);
    cmp("held_hours", 32'(bus.current_hours), 0);
    cmp("held_enabled", 32'(bus.alarm_enabled), 0);
    bus.btn_set_time = 1'b0;
    @(negedge clk);
    bus.btn_set_time = 1'b1;
    @(negedge clk);
    cmp("first_press_mode", 32'(bus.mode), 1);
    bus.btn_set_time = 1'b0;
    @(negedge clk);

    // 2: time setting with wrap, frozen time, secs clear on leaving SET_TIME
    pulse(1, 25);
    cmp("hours_25", 32'(bus.current_hours), 1);
    pulse(0, 1);
    cmp("mode_st_m", 32'(bus.mode), 2);
    pulse(2, 61);
    cmp("mins_61", 32'(bus.current_mins), 1);
    s0 = bus.current_secs;
    repeat (40) @(negedge clk);
    cmp("frozen_secs", 32'(bus.current_secs), 32'(s0));
    pulse(0, 1);
    cmp("mode_sa_h", 32'(bus.mode), 3);
    cmp("secs_cleared", 32'(bus.current_secs), 0);

    // 3: rollover from 23:59:59
    pulse(0, 3);
    pulse(1, 22);
    pulse(0, 1);
    pulse(2, 58);
    pulse(0, 3);
    cmp("run_mode", 32'(bus.mode), 0);
    cmp("preload_h", 32'(bus.current_hours), 23);
    cmp("preload_m", 32'(bus.current_mins), 59);
    wait_secs(59, 400);
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.current_secs != 8'd59) begin n = i; break; end
    end
    cmp("rollover_cycles", n, 4);
    cmp("rollover_h", 32'(bus.current_hours), 0);
    cmp("rollover_m", 32'(bus.current_mins), 0);
    cmp("rollover_s", 32'(bus.current_secs), 0);

    // 4: alarm at 00:01, dismiss, re-trigger, auto-clear
    pulse(0, 4);
    pulse(2, 1);
    cmp("alarm_m", 32'(bus.alarm_mins), 1);
    cmp("alarm_h", 32'(bus.alarm_hours), 0);
    pulse(0, 1);
    pulse(3, 1);
    cmp("enabled", 32'(bus.alarm_enabled), 1);
    wait_active(1'b1, 400);
    cmp("trig_m", 32'(bus.current_mins), 1);
    cmp("trig_s", 32'(bus.current_secs), 0);
    pulse(1, 1);
    cmp("dismissed", 32'(bus.alarm_active), 0);
    cmp("dismiss_hours", 32'(bus.current_hours), 0);
    pulse(0, 2);
    pulse(2, 59);
    pulse(0, 3);
    cmp("rewind_m", 32'(bus.current_mins), 0);
    wait_active(1'b1, 400);
    cmp("retrig_m", 32'(bus.current_mins), 1);
    wait_active(1'b0, 400);
    cmp("autoclr_h", 32'(bus.current_hours), 0);
    cmp("autoclr_m", 32'(bus.current_mins), 2);
    cmp("autoclr_s", 32'(bus.current_secs), 0);

    // 5: set_time beats inc in the same cycle; inc ignored in RUN
    pulse(0, 1);
    bus.btn_set_time = 1'b1; bus.btn_inc_hours = 1'b1;
    @(negedge clk);
    bus.btn_set_time = 1'b0; bus.btn_inc_hours = 1'b0;
    @(negedge clk);
    cmp("simul_mode", 32'(bus.mode), 2);
    cmp("simul_hours", 32'(bus.current_hours), 0);
    pulse(0, 3);
    pulse(1, 1);
    pulse(2, 1);
    cmp("run_inc_h", 32'(bus.current_hours), 0);
    cmp("run_inc_m", 32'(bus.current_mins), 2);

    // 6: asynchronous reset in the middle of setting
    pulse(0, 4);
    pulse(2, 29);
    cmp("pre_reset_mode", 32'(bus.mode), 4);
    cmp("pre_reset_al_m", 32'(bus.alarm_mins), 30);
    #2 reset = 1'b1;
    #1;
    cmp("async_mode", 32'(bus.mode), 0);
    cmp("async_mins", 32'(bus.current_mins), 0);
    cmp("async_al_m", 32'(bus.alarm_mins), 0);
    cmp("async_enabled", 32'(bus.alarm_enabled), 0);
    cmp("async_active", 32'(bus.alarm_active), 0);
    @(negedge clk);
    reset = 1'b0;

    // random traffic against the model
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      bus.btn_set_time  = ($urandom_range(0, 99) < 12);
      bus.btn_inc_hours = ($urandom_range(0, 99) < 25);
      bus.btn_inc_mins  = ($urandom_range(0, 99) < 25);
      bus.btn_alarm_en  = ($urandom_range(0, 99) < 6);
    end
    @(negedge clk);
    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
